key_event_fifo: RTL and testbench

Buffers key press/release events produced by the PS/2 keyboard decoder so that slower consumers (game logic, display controllers, text entry) can drain them with a valid/ready handshake instead of polling the 512-bit key map. Each `key_valid` pulse from the decoder becomes one queued entry: the 9-bit extended key code and a press/release flag. The block sits directly downstream of the keyboard decoder and upstream of application logic.

---
 rtl/key_event_fifo.sv | 95 +++++++++
 tb/tb_key_event_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/key_event_fifo.sv
// Key event FIFO: queues {press, code} entries from the PS/2 decoder behind a valid/ready drain port.
// Optional typematic-repeat suppression is compiled in with `define KEY_REPEAT_FILTER_EN.
module key_event_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [8:0]       last_change,
    input  logic [511:0]     key_down,
    output logic             evt_valid,
    output logic [8:0]       evt_code,
    output logic             evt_press,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    input  logic             clr_overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [9:0]       mem [DEPTH];
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic             full;
    logic             empty;
    logic             key_press;
    logic             push_req;
    logic             do_push;
    logic             do_pop;
    logic             ovf_set;

    assign wr_addr   = wr_ptr[AW-1:0];
    assign rd_addr   = rd_ptr[AW-1:0];
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[CNT_W-1] != rd_ptr[CNT_W-1]) && (wr_addr == rd_addr);
    assign key_press = key_down[last_change];

`ifdef KEY_REPEAT_FILTER_EN
    // Keys already reported as down; a press seen again is a typematic repeat.
    logic [511:0] shadow;

    assign push_req = key_valid && !(key_press && shadow[last_change]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (key_valid) begin
            shadow[last_change] <= key_press;
        end
    end
`else
    assign push_req = key_valid;
`endif

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = !empty && evt_ready;
    assign do_push = push_req && (!full || do_pop);
    assign ovf_set = push_req && full && !do_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage needs no reset: emptiness is decided by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_addr] <= {key_press, last_change};
        end
    end

    assign evt_valid              = !empty;
    assign {evt_press, evt_code}  = mem[rd_addr];
    assign count                  = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_key_event_fifo.sv
// Directed bench for key_event_fifo: vector table for the basic handshake plus hand-written
// sequences for overflow, wrap, repeat filtering and asynchronous reset.
module tb_key_event_fifo;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             key_valid;
    logic [8:0]       last_change;
    logic [511:0]     key_down;
    logic             evt_valid;
    logic [8:0]       evt_code;
    logic             evt_press;
    logic             evt_ready;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             clr_overflow;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    key_event_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .last_change  (last_change),
        .key_down     (key_down),
        .evt_valid    (evt_valid),
        .evt_code     (evt_code),
        .evt_press    (evt_press),
        .evt_ready    (evt_ready),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    typedef struct {
        logic       kv;
        logic [8:0] code;
        logic       press;
        logic       ready;
        logic       chk_head;
        logic       exp_valid;
        logic [8:0] exp_code;
        logic       exp_press;
        logic [3:0] exp_count;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // The decoder updates key_down in the same cycle it strobes key_valid.
    task automatic set_in(input logic kv, input logic [8:0] code, input logic press,
                          input logic ready, input logic clr);
        key_valid    = kv;
        last_change  = code;
        if (kv) key_down[code] = press;
        evt_ready    = ready;
        clr_overflow = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] exp_drain;
        logic       rep_press[4];
        int         rep_n;

        vecs[0] = '{1'b1, 9'h01C, 1'b1, 1'b1, 1'b1, 1'b1, 9'h01C, 1'b1, 4'd1, 1'b0};
        vecs[1] = '{1'b1, 9'h01C, 1'b0, 1'b1, 1'b1, 1'b1, 9'h01C, 1'b0, 4'd1, 1'b0};
        vecs[2] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 4'd0, 1'b0};
        vecs[3] = '{1'b1, 9'h175, 1'b1, 1'b0, 1'b1, 1'b1, 9'h175, 1'b1, 4'd1, 1'b0};
        vecs[4] = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b1, 9'h175, 1'b1, 4'd1, 1'b0};
        vecs[5] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 4'd0, 1'b0};

        rst_n    = 1'b0;
        key_down = '0;
        set_in(1'b0, 9'h0, 1'b0, 1'b0, 1'b0);
        #23;
        rst_n = 1'b1;
        #1;
        chk("reset_valid", 16'(evt_valid), 16'd0);
        chk("reset_count", 16'(count), 16'd0);
        chk("reset_ovf", 16'(overflow), 16'd0);
        tick();

        // Basic press/release and extended-key hold
        for (int i = 0; i < 6; i++) begin
            set_in(vecs[i].kv, vecs[i].code, vecs[i].press, vecs[i].ready, 1'b0);
            tick();
            chk($sformatf("vec%0d_valid", i), 16'(evt_valid), 16'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_count", i), 16'(count), 16'(vecs[i].exp_count));
            chk($sformatf("vec%0d_ovf", i), 16'(overflow), 16'(vecs[i].exp_ovf));
            if (vecs[i].chk_head) begin
                chk($sformatf("vec%0d_code", i), 16'(evt_code), 16'(vecs[i].exp_code));
                chk($sformatf("vec%0d_press", i), 16'(evt_press), 16'(vecs[i].exp_press));
            end
        end

        // Overflow: 9 pushes into 8 entries with no consumer
        for (int i = 0; i < 9; i++) begin
            set_in(1'b1, 9'(9'h010 + i), 1'b1, 1'b0, 1'b0);
            tick();
            chk($sformatf("fill%0d_count", i), 16'(count), 16'((i < 8) ? i + 1 : 8));
            chk($sformatf("fill%0d_ovf", i), 16'(overflow), 16'(i == 8));
        end
        chk("full_head", 16'(evt_code), 16'h010);
        set_in(1'b0, 9'h0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("clr_ovf", 16'(overflow), 16'd0);
        chk("clr_count", 16'(count), 16'd8);
        set_in(1'b1, 9'h020, 1'b1, 1'b1, 1'b0);
        tick();
        chk("fullpp_count", 16'(count), 16'd8);
        chk("fullpp_ovf", 16'(overflow), 16'd0);
        chk("fullpp_head", 16'(evt_code), 16'h011);
        set_in(1'b1, 9'h021, 1'b1, 1'b0, 1'b1);
        tick();
        chk("setwins_ovf", 16'(overflow), 16'd1);
        chk("setwins_head", 16'(evt_code), 16'h011);
        set_in(1'b0, 9'h0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("clr2_ovf", 16'(overflow), 16'd0);
        for (int i = 0; i < 8; i++) begin
            exp_drain = (i < 7) ? 9'(9'h011 + i) : 9'h020;
            chk($sformatf("drain%0d_code", i), 16'(evt_code), 16'(exp_drain));
            set_in(1'b0, 9'h0, 1'b0, 1'b1, 1'b0);
            tick();
            chk($sformatf("drain%0d_count", i), 16'(count), 16'(7 - i));
        end

        // Wrap: pointers go around twice with one entry in flight
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 9'(9'h040 + i), 1'b1, 1'b1, 1'b0);
            tick();
            chk($sformatf("wrap%0d_code", i), 16'(evt_code), 16'(9'h040 + i));
            chk($sformatf("wrap%0d_count", i), 16'(count), 16'd1);
        end
        set_in(1'b0, 9'h0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("wrap_end_count", 16'(count), 16'd0);
        chk("wrap_end_valid", 16'(evt_valid), 16'd0);

        // Typematic repeat of 0x29
`ifdef KEY_REPEAT_FILTER_EN
        rep_n = 2;
        rep_press[0] = 1'b1; rep_press[1] = 1'b0;
        rep_press[2] = 1'b0; rep_press[3] = 1'b0;
`else
        rep_n = 4;
        rep_press[0] = 1'b1; rep_press[1] = 1'b1;
        rep_press[2] = 1'b1; rep_press[3] = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 9'h029, 1'b1, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, 9'h029, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 9'h0, 1'b0, 1'b0, 1'b0);
        chk("rep_count", 16'(count), 16'(rep_n));
        chk("rep_ovf", 16'(overflow), 16'd0);
        for (int i = 0; i < rep_n; i++) begin
            chk($sformatf("rep%0d_code", i), 16'(evt_code), 16'h029);
            chk($sformatf("rep%0d_press", i), 16'(evt_press), 16'(rep_press[i]));
            set_in(1'b0, 9'h0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        chk("rep_end_count", 16'(count), 16'd0);

        // Asynchronous reset with 5 entries and overflow pending
        for (int i = 0; i < 9; i++) begin
            set_in(1'b1, 9'(9'h060 + i), 1'b1, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 9'h0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        set_in(1'b0, 9'h0, 1'b0, 1'b0, 1'b0);
        chk("prerst_count", 16'(count), 16'd5);
        chk("prerst_ovf", 16'(overflow), 16'd1);
        chk("prerst_head", 16'(evt_code), 16'h063);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 16'(evt_valid), 16'd0);
        chk("arst_count", 16'(count), 16'd0);
        chk("arst_ovf", 16'(overflow), 16'd0);
        tick();
        rst_n = 1'b1;
        set_in(1'b1, 9'h033, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 9'h0, 1'b0, 1'b0, 1'b0);
        chk("postrst_valid", 16'(evt_valid), 16'd1);
        chk("postrst_code", 16'(evt_code), 16'h033);
        chk("postrst_count", 16'(count), 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
